if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 114 +++++++++++
 tb/tb_if_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and the
// BOOT/RUN/MISS fetch controller with stall and fetch counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        memStall,
    input  logic        hazardStall,
    input  logic        jumpTaken,
    input  logic [31:0] jumpTarget,
    input  logic [31:0] instIn,
    output logic [31:0] addressInst,
    output logic        jumpTakedOut,
    output logic [31:0] instOut,
    output logic [31:0] pcOut,
    output logic        validOut,
    output logic [15:0] stallCycles,
    output logic [15:0] fetchCount
);

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StMiss
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        fetch_cnt_d = fetch_cnt_q;

        if (state_q == StMiss && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end

        unique case (state_q)
            StBoot: begin
                state_d = StRun;
            end
            StRun, StMiss: begin
                if (jumpTaken) begin
                    pc_d     = {jumpTarget[31:2], 2'b00};
                    inst_d   = NOP_INST;
                    pc_out_d = 32'h0;
                    valid_d  = 1'b0;
                    state_d  = StRun;
                end else if (hazardStall) begin
                    // Decode owns IF/ID this cycle; only track the memory side.
                    state_d = memStall ? StMiss : StRun;
                end else if (memStall) begin
                    inst_d   = NOP_INST;
                    pc_out_d = 32'h0;
                    valid_d  = 1'b0;
                    state_d  = StMiss;
                end else begin
                    inst_d   = instIn;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    state_d  = StRun;
                    if (fetch_cnt_q != 16'hFFFF) begin
                        fetch_cnt_d = fetch_cnt_q + 16'd1;
                    end
                end
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StBoot;
            pc_q        <= RESET_PC;
            inst_q      <= NOP_INST;
            pc_out_q    <= 32'h0;
            valid_q     <= 1'b0;
            stall_cnt_q <= 16'h0;
            fetch_cnt_q <= 16'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign addressInst  = pc_q;
    assign jumpTakedOut = jumpTaken && !reset && (state_q != StBoot);
    assign instOut      = inst_q;
    assign pcOut        = pc_out_q;
    assign validOut     = valid_q;
    assign stallCycles  = stall_cnt_q;
    assign fetchCount   = fetch_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: expected IF/ID contents are queued when a
// cycle's stimulus is driven and compared after the clock edge.
module tb_if_stage;

    localparam logic [31:0] Nop = 32'h00000013;

    logic        clock = 1'b0;
    logic        reset, memStall, hazardStall, jumpTaken;
    logic [31:0] jumpTarget, instIn;
    logic [31:0] addressInst, instOut, pcOut;
    logic        jumpTakedOut, validOut;
    logic [15:0] stallCycles, fetchCount;
    logic [31:0] w_addressInst, w_instOut, w_pcOut;
    logic        w_jumpTakedOut, w_validOut;
    logic [15:0] w_stallCycles, w_fetchCount;

    always #5 clock = ~clock;

    // Instruction memory stand-in: word at address A is 32'hA0 + A.
    assign instIn = 32'hA0 + addressInst;

    if_stage u_dut (
        .clock       (clock),
        .reset       (reset),
        .memStall    (memStall),
        .hazardStall (hazardStall),
        .jumpTaken   (jumpTaken),
        .jumpTarget  (jumpTarget),
        .instIn      (instIn),
        .addressInst (addressInst),
        .jumpTakedOut(jumpTakedOut),
        .instOut     (instOut),
        .pcOut       (pcOut),
        .validOut    (validOut),
        .stallCycles (stallCycles),
        .fetchCount  (fetchCount)
    );

    if_stage #(.RESET_PC(32'hFFFFFFF8)) u_wrap (
        .clock       (clock),
        .reset       (reset),
        .memStall    (memStall),
        .hazardStall (hazardStall),
        .jumpTaken   (jumpTaken),
        .jumpTarget  (jumpTarget),
        .instIn      (instIn),
        .addressInst (w_addressInst),
        .jumpTakedOut(w_jumpTakedOut),
        .instOut     (w_instOut),
        .pcOut       (w_pcOut),
        .validOut    (w_validOut),
        .stallCycles (w_stallCycles),
        .fetchCount  (w_fetchCount)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pco;
        logic [31:0] addr;
        logic        valid;
        logic [15:0] stall;
        logic [15:0] fetch;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: 0 = boot, 1 = run, 2 = miss.
    int          m_state;
    logic [31:0] m_pc, m_inst, m_pco;
    logic        m_valid;
    logic [15:0] m_stall, m_fetch;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cycle(input string tag, input logic rst, input logic mem, input logic haz,
                         input logic jmp, input logic [31:0] tgt);
        exp_t e;
        reset       = rst;
        memStall    = mem;
        hazardStall = haz;
        jumpTaken   = jmp;
        jumpTarget  = tgt;
        #1;
        check_eq({tag, ".jumpTakedOut"}, {31'h0, jumpTakedOut},
                 {31'h0, jmp && !rst && (m_state != 0)});
        if (rst) begin
            m_state = 0; m_pc = 32'h0; m_inst = Nop; m_pco = 32'h0;
            m_valid = 1'b0; m_stall = 16'h0; m_fetch = 16'h0;
        end else begin
            if (m_state == 2 && m_stall != 16'hFFFF) m_stall++;
            if (m_state == 0) begin
                m_state = 1;
            end else if (jmp) begin
                m_pc = tgt & 32'hFFFFFFFC;
                m_inst = Nop; m_pco = 32'h0; m_valid = 1'b0; m_state = 1;
            end else if (haz) begin
                m_state = mem ? 2 : 1;
            end else if (mem) begin
                m_inst = Nop; m_pco = 32'h0; m_valid = 1'b0; m_state = 2;
            end else begin
                m_inst = 32'hA0 + m_pc; m_pco = m_pc; m_valid = 1'b1;
                m_pc = m_pc + 32'd4; m_state = 1;
                if (m_fetch != 16'hFFFF) m_fetch++;
            end
        end
        e.inst = m_inst; e.pco = m_pco; e.addr = m_pc; e.valid = m_valid;
        e.stall = m_stall; e.fetch = m_fetch;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_eq({tag, ".instOut"}, instOut, e.inst);
        check_eq({tag, ".pcOut"}, pcOut, e.pco);
        check_eq({tag, ".addressInst"}, addressInst, e.addr);
        check_eq({tag, ".validOut"}, {31'h0, validOut}, {31'h0, e.valid});
        check_eq({tag, ".stallCycles"}, {16'h0, stallCycles}, {16'h0, e.stall});
        check_eq({tag, ".fetchCount"}, {16'h0, fetchCount}, {16'h0, e.fetch});
    endtask

    initial begin
        reset = 1'b1; memStall = 1'b0; hazardStall = 1'b0; jumpTaken = 1'b0;
        jumpTarget = 32'h0;
        m_state = 0; m_pc = 32'h0; m_inst = Nop; m_pco = 32'h0;
        m_valid = 1'b0; m_stall = 16'h0; m_fetch = 16'h0;
        @(posedge clock);
        #1;

        // Reset with a simultaneous jump request must still land in BOOT.
        cycle("rst0", 1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
        cycle("rst1", 1'b1, 1'b0, 1'b0, 1'b1, 32'h40);
        check_eq("wrap.reset", w_addressInst, 32'hFFFFFFF8);

        // Boot cycle ignores a jump, then three plain fetches.
        cycle("boot", 1'b0, 1'b0, 1'b0, 1'b1, 32'h80);
        check_eq("boot.pc_held", addressInst, 32'h0);
        check_eq("wrap.boot", w_addressInst, 32'hFFFFFFF8);
        cycle("adv0", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("wrap.adv0", w_addressInst, 32'hFFFFFFFC);
        cycle("adv1", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("wrap.adv1", w_addressInst, 32'h00000000);
        cycle("adv2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("seq.inst", instOut, 32'hA8);
        check_eq("seq.pc", pcOut, 32'h8);
        check_eq("seq.fetch", {16'h0, fetchCount}, 32'd3);
        cycle("adv3", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Three-cycle memory stall at PC 0x10.
        for (int i = 0; i < 3; i++) cycle("miss", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("miss.pc_held", addressInst, 32'h10);
        cycle("miss_exit", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("miss.capture_pc", pcOut, 32'h10);
        check_eq("miss.stall_cnt", {16'h0, stallCycles}, 32'd3);

        // Load-use stall holds IF/ID (pcOut 0x14) and PC.
        cycle("adv4", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 2; i++) cycle("haz", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("haz.pc_out", pcOut, 32'h14);
        check_eq("haz.inst", instOut, 32'hB4);
        check_eq("haz.pc", addressInst, 32'h18);
        check_eq("haz.fetch", {16'h0, fetchCount}, 32'd6);

        // Hazard together with a miss, then hazard alone while in MISS.
        cycle("hazmiss", 1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        cycle("haz_in_miss", 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        cycle("adv5", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cycle("adv6", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        // Jump wins over both stalls; target is word-aligned.
        check_eq("jmp.pc_before", addressInst, 32'h20);
        cycle("jmp", 1'b0, 1'b1, 1'b1, 1'b1, 32'h103);
        check_eq("jmp.target", addressInst, 32'h100);
        cycle("jmp_next", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("jmp.first_fetch", instOut, 32'h1A0);

        // Enter MISS until stallCycles reaches 5, then reset mid-miss.
        cycle("miss2a", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("miss2b", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        check_eq("miss2.stall_cnt", {16'h0, stallCycles}, 32'd5);
        cycle("rst_miss", 1'b1, 1'b1, 1'b0, 1'b1, 32'h200);
        check_eq("rst_miss.valid", {31'h0, validOut}, 32'd0);
        check_eq("rst_miss.fetch", {16'h0, fetchCount}, 32'd0);
        cycle("boot2", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("boot2.pc_held", addressInst, 32'h0);

        // Long miss to exercise stallCycles saturation.
        cycle("sat_enter", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (65540) @(posedge clock);
        #1;
        m_stall = 16'hFFFF;
        check_eq("sat.stall", {16'h0, stallCycles}, 32'h0000FFFF);
        cycle("sat_hold", 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("sat_exit", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
